// File: rtl/cpu_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// cpu_ctrl_pkg
// Shared encodings for the multi-cycle CPU control unit.
//   - 3-bit control-state codes (IF .. WB_5stages)
//   - 6-bit opcode values
// Imported by the sequencer, its next-state decoder and the downstream
// control-signal output function so all agree on one encoding.
// ---------------------------------------------------------------------------
package cpu_ctrl_pkg;

    // Control states
    localparam logic [2:0] ST_IF   = 3'b000;
    localparam logic [2:0] ST_ID   = 3'b001;
    localparam logic [2:0] ST_EXE3 = 3'b101;
    localparam logic [2:0] ST_EXE4 = 3'b110;
    localparam logic [2:0] ST_EXE5 = 3'b010;
    localparam logic [2:0] ST_MEM  = 3'b011;
    localparam logic [2:0] ST_WB4  = 3'b111;
    localparam logic [2:0] ST_WB5  = 3'b100;

    // Opcodes
    localparam logic [5:0] OP_ADD  = 6'b000000;
    localparam logic [5:0] OP_SUB  = 6'b000001;
    localparam logic [5:0] OP_ADDI = 6'b000010;
    localparam logic [5:0] OP_OR   = 6'b010000;
    localparam logic [5:0] OP_AND  = 6'b010001;
    localparam logic [5:0] OP_ORI  = 6'b010010;
    localparam logic [5:0] OP_SLL  = 6'b011000;
    localparam logic [5:0] OP_MOVE = 6'b100000;
    localparam logic [5:0] OP_SLT  = 6'b100111;
    localparam logic [5:0] OP_SW   = 6'b110000;
    localparam logic [5:0] OP_LW   = 6'b110001;
    localparam logic [5:0] OP_BEQ  = 6'b110100;
    localparam logic [5:0] OP_J    = 6'b111000;
    localparam logic [5:0] OP_JR   = 6'b111001;
    localparam logic [5:0] OP_JAL  = 6'b111010;
    localparam logic [5:0] OP_HALT = 6'b111111;

endpackage

// File: rtl/ctrl_next_state.sv
// ---------------------------------------------------------------------------
// ctrl_next_state
// Purely combinational next-state and illegal-opcode decode.
// Ports:
//   state      in  3  current control state
//   opcode     in  6  opcode presented to the control unit
//   next_state out 3  state to enter on the next unstalled edge
//   illegal_op out 1  current ID opcode is undefined
// Stall and halt overrides are applied by the instantiating sequencer.
// ---------------------------------------------------------------------------
module ctrl_next_state
    import cpu_ctrl_pkg::*;
(
    input  logic [2:0] state,
    input  logic [5:0] opcode,
    output logic [2:0] next_state,
    output logic       illegal_op
);

    always_comb begin
        next_state = ST_IF;
        illegal_op = 1'b0;
        case (state)
            ST_IF:   next_state = (opcode == OP_HALT) ? ST_IF : ST_ID;
            ST_ID: begin
                case (opcode)
                    OP_J, OP_JAL, OP_JR: next_state = ST_IF;
                    OP_BEQ:              next_state = ST_EXE3;
                    OP_LW, OP_SW:        next_state = ST_EXE5;
                    OP_ADD, OP_ADDI, OP_SUB, OP_ORI, OP_AND,
                    OP_OR, OP_MOVE, OP_SLL, OP_SLT:
                                         next_state = ST_EXE4;
                    default: begin
                        next_state = ST_IF;
                        illegal_op = 1'b1;
                    end
                endcase
            end
            ST_EXE3: next_state = ST_IF;
            ST_EXE4: next_state = ST_WB4;
            ST_WB4:  next_state = ST_IF;
            ST_EXE5: next_state = ST_MEM;
            // Only lw needs a write-back; sw (and anything else) retires here.
            ST_MEM:  next_state = (opcode == OP_LW) ? ST_WB5 : ST_IF;
            ST_WB5:  next_state = ST_IF;
            default: next_state = ST_IF;
        endcase
    end

endmodule

// File: rtl/multicycle_state_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_state_ctrl
// Sequencer for the multi-cycle CPU control unit: holds the control state,
// the instruction register and the debug counters.
// Ports:
//   CLK       in   1      system clock, rising edge
//   RST_n     in   1      asynchronous active-low reset
//   InsIn     in   32     instruction word at the current PC
//   Stall     in   1      freeze (single-step debug)
//   state     out  3      current control state
//   Opcode    out  6      live InsIn opcode in IF, else IR opcode
//   IR        out  32     latched instruction
//   IRWre     out  1      IR load enable
//   Halted    out  1      sticky halt status
//   IllegalOp out  1      one-cycle pulse after an undefined opcode in ID
//   CycleCnt  out  CNT_W  cycles since reset while not halted
//   InstrCnt  out  CNT_W  retired instructions
// ---------------------------------------------------------------------------
module multicycle_state_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RST_n,
    input  logic [31:0]      InsIn,
    input  logic             Stall,
    output logic [2:0]       state,
    output logic [5:0]       Opcode,
    output logic [31:0]      IR,
    output logic             IRWre,
    output logic             Halted,
    output logic             IllegalOp,
    output logic [CNT_W-1:0] CycleCnt,
    output logic [CNT_W-1:0] InstrCnt
);

    logic [2:0]       state_reg;
    logic [31:0]      ir_reg;
    logic             halted_reg;
    logic             illegal_reg;
    logic [CNT_W-1:0] cycle_cnt_reg;
    logic [CNT_W-1:0] instr_cnt_reg;

    logic [2:0]       state_next;
    logic             illegal_next;
    logic [5:0]       opcode_cur;
    logic             fetch_halt;
    logic             advance;
    logic             retire;

    // In IF the opcode comes straight from instruction memory so a halt can
    // be seen (and PC writes gated) before anything is latched.
    assign opcode_cur = (state_reg == ST_IF) ? InsIn[31:26] : ir_reg[31:26];
    assign fetch_halt = (state_reg == ST_IF) && (InsIn[31:26] == OP_HALT);
    assign advance    = !Stall && !halted_reg;
    assign IRWre      = (state_reg == ST_IF) && advance && !fetch_halt;

    ctrl_next_state u_next_state (
        .state      (state_reg),
        .opcode     (opcode_cur),
        .next_state (state_next),
        .illegal_op (illegal_next)
    );

    // An instruction retires when it leaves a non-IF state back into IF;
    // the illegal-opcode bailout from ID is not a retirement.
    assign retire = advance && (state_reg != ST_IF) && (state_next == ST_IF)
                    && !illegal_next;

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_reg     <= ST_IF;
            ir_reg        <= '0;
            halted_reg    <= 1'b0;
            illegal_reg   <= 1'b0;
            cycle_cnt_reg <= '0;
            instr_cnt_reg <= '0;
        end else begin
            // Cycle counter runs through stalls but stops once halted.
            if (!halted_reg) begin
                cycle_cnt_reg <= cycle_cnt_reg + CNT_W'(1);
            end
            illegal_reg <= advance && illegal_next;
            if (advance) begin
                state_reg <= state_next;
                if (fetch_halt) begin
                    halted_reg <= 1'b1;
                end
                if (retire) begin
                    instr_cnt_reg <= instr_cnt_reg + CNT_W'(1);
                end
            end
            if (IRWre) begin
                ir_reg <= InsIn;
            end
        end
    end

    assign state     = state_reg;
    assign Opcode    = opcode_cur;
    assign IR        = ir_reg;
    assign Halted    = halted_reg;
    assign IllegalOp = illegal_reg;
    assign CycleCnt  = cycle_cnt_reg;
    assign InstrCnt  = instr_cnt_reg;

endmodule

// File: tb/tb_multicycle_state_ctrl.sv
// ---------------------------------------------------------------------------
// tb_multicycle_state_ctrl
// Self-checking bench: directed sequences with literal expectations plus a
// randomized run, all compared every negedge against a path-queue model.
// ---------------------------------------------------------------------------
module tb_multicycle_state_ctrl;

    localparam int CNT_W = 32;

    // Encodings written out independently of the design package.
    localparam logic [5:0] B_ADD = 6'b000000, B_SUB = 6'b000001, B_ADDI = 6'b000010;
    localparam logic [5:0] B_OR = 6'b010000, B_AND = 6'b010001, B_ORI = 6'b010010;
    localparam logic [5:0] B_SLL = 6'b011000, B_MOVE = 6'b100000, B_SLT = 6'b100111;
    localparam logic [5:0] B_SW = 6'b110000, B_LW = 6'b110001, B_BEQ = 6'b110100;
    localparam logic [5:0] B_J = 6'b111000, B_JR = 6'b111001, B_JAL = 6'b111010;
    localparam logic [5:0] B_HALT = 6'b111111;

    logic             CLK;
    logic             RST_n;
    logic [31:0]      InsIn;
    logic             Stall;
    logic [2:0]       state;
    logic [5:0]       Opcode;
    logic [31:0]      IR;
    logic             IRWre;
    logic             Halted;
    logic             IllegalOp;
    logic [CNT_W-1:0] CycleCnt;
    logic [CNT_W-1:0] InstrCnt;

    multicycle_state_ctrl #(.CNT_W(CNT_W)) dut (
        .CLK       (CLK),
        .RST_n     (RST_n),
        .InsIn     (InsIn),
        .Stall     (Stall),
        .state     (state),
        .Opcode    (Opcode),
        .IR        (IR),
        .IRWre     (IRWre),
        .Halted    (Halted),
        .IllegalOp (IllegalOp),
        .CycleCnt  (CycleCnt),
        .InstrCnt  (InstrCnt)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // An instruction is a list of states it visits after IF; when the list
    // runs out the machine is back in IF.
    logic [2:0]       m_state = 3'b000;
    logic [31:0]      m_ir    = '0;
    logic             m_halt  = 1'b0;
    logic             m_ill   = 1'b0;
    logic             m_bad   = 1'b0;
    logic [CNT_W-1:0] m_cyc   = '0;
    logic [CNT_W-1:0] m_instr = '0;
    logic [2:0]       mq[$];

    function automatic bit is_legal(input logic [5:0] op);
        return op inside {B_ADD, B_SUB, B_ADDI, B_OR, B_AND, B_ORI, B_SLL, B_MOVE,
                          B_SLT, B_SW, B_LW, B_BEQ, B_J, B_JR, B_JAL};
    endfunction

    task automatic load_path(input logic [5:0] op);
        mq.delete();
        mq.push_back(3'b001);
        if (op == B_BEQ) begin
            mq.push_back(3'b101);
        end else if (op == B_LW) begin
            mq.push_back(3'b010); mq.push_back(3'b011); mq.push_back(3'b100);
        end else if (op == B_SW) begin
            mq.push_back(3'b010); mq.push_back(3'b011);
        end else if (is_legal(op) && !(op inside {B_J, B_JR, B_JAL})) begin
            mq.push_back(3'b110); mq.push_back(3'b111);
        end
    endtask

    always @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            m_state = 3'b000; m_ir = '0; m_halt = 1'b0; m_ill = 1'b0;
            m_bad = 1'b0; m_cyc = '0; m_instr = '0; mq.delete();
        end else begin
            m_ill = 1'b0;
            if (!m_halt) begin
                m_cyc = m_cyc + 1;
                if (!Stall) begin
                    if (m_state == 3'b000) begin
                        if (InsIn[31:26] == B_HALT) begin
                            m_halt = 1'b1;
                        end else begin
                            m_ir  = InsIn;
                            m_bad = !is_legal(InsIn[31:26]);
                            load_path(InsIn[31:26]);
                            m_state = mq.pop_front();
                        end
                    end else if (mq.size() > 0) begin
                        m_state = mq.pop_front();
                    end else begin
                        m_state = 3'b000;
                        if (m_bad) m_ill = 1'b1;
                        else       m_instr = m_instr + 1;
                    end
                end
            end
        end
    end

    // Compare process: every negedge, all outputs against the model.
    always @(negedge CLK) begin
        chk("state", 64'(state), 64'(m_state));
        chk("Opcode", 64'(Opcode), 64'((m_state == 3'b000) ? InsIn[31:26] : m_ir[31:26]));
        chk("IR", 64'(IR), 64'(m_ir));
        chk("IRWre", 64'(IRWre), 64'((m_state == 3'b000) && !Stall && !m_halt
                                     && (InsIn[31:26] != B_HALT)));
        chk("Halted", 64'(Halted), 64'(m_halt));
        chk("IllegalOp", 64'(IllegalOp), 64'(m_ill));
        chk("CycleCnt", 64'(CycleCnt), 64'(m_cyc));
        chk("InstrCnt", 64'(InstrCnt), 64'(m_instr));
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input logic [31:0] ins, input logic st);
        InsIn = ins;
        Stall = st;
        @(posedge CLK);
        #2;
    endtask

    task automatic do_reset();
        RST_n = 1'b0;
        InsIn = 32'h0;
        Stall = 1'b0;
        @(posedge CLK);
        #2;
        RST_n = 1'b1;
    endtask

    function automatic logic [31:0] word(input logic [5:0] op);
        return {op, 26'($urandom)};
    endfunction

    // Garbage words never reach IF fetch: callers only use them past IF.
    task automatic run_seq(input string nm, input logic [5:0] op,
                           input logic [2:0] exp_st[6], input int n);
        for (int i = 0; i < n; i++) begin
            step((i == 0) ? word(op) : $urandom, 1'b0);
            chk(nm, 64'(state), 64'(exp_st[i]));
        end
    endtask

    logic [5:0]  legal_ops[15] = '{B_ADD, B_SUB, B_ADDI, B_OR, B_AND, B_ORI, B_SLL,
                                   B_MOVE, B_SLT, B_SW, B_LW, B_BEQ, B_J, B_JR, B_JAL};
    logic [31:0] w;
    logic [2:0]  seq[6];
    logic [5:0]  rop;

    initial begin
        RST_n = 1'b1;
        InsIn = 32'h0;
        Stall = 1'b0;
        #1;
        do_reset();

        // Reset state
        chk("rst_state", 64'(state), 64'h0);
        chk("rst_IR", 64'(IR), 64'h0);
        chk("rst_cyc", 64'(CycleCnt), 64'h0);
        chk("rst_instr", 64'(InstrCnt), 64'h0);
        chk("rst_halted", 64'(Halted), 64'h0);

        // add: 000,001,110,111,000
        w = {B_ADD, 26'h0123456};
        step(w, 1'b0);
        chk("add_st1", 64'(state), 64'h1);
        chk("add_ir", 64'(IR), 64'(w));
        step(32'hDEAD_BEEF, 1'b0);
        chk("add_st2", 64'(state), 64'h6);
        chk("add_opc_ir", 64'(Opcode), 64'(B_ADD));
        step(32'hFFFF_FFFF, 1'b0);
        chk("add_st3", 64'(state), 64'h7);
        step(32'h1234_5678, 1'b0);
        chk("add_st4", 64'(state), 64'h0);
        chk("add_instr", 64'(InstrCnt), 64'h1);
        chk("add_cyc", 64'(CycleCnt), 64'h4);

        // lw / sw / beq / j back to back
        do_reset();
        InsIn = {B_LW, 26'h2AAAAAA};
        #1;
        chk("opc_live", 64'(Opcode), 64'(B_LW));
        seq = '{3'b001, 3'b010, 3'b011, 3'b100, 3'b000, 3'b000};
        run_seq("lw_seq", B_LW, seq, 5);
        chk("lw_instr", 64'(InstrCnt), 64'h1);
        seq = '{3'b001, 3'b010, 3'b011, 3'b000, 3'b000, 3'b000};
        run_seq("sw_seq", B_SW, seq, 4);
        chk("sw_instr", 64'(InstrCnt), 64'h2);
        seq = '{3'b001, 3'b101, 3'b000, 3'b000, 3'b000, 3'b000};
        run_seq("beq_seq", B_BEQ, seq, 3);
        chk("beq_instr", 64'(InstrCnt), 64'h3);
        seq = '{3'b001, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
        run_seq("j_seq", B_J, seq, 2);
        chk("j_instr", 64'(InstrCnt), 64'h4);
        chk("seq_cyc", 64'(CycleCnt), 64'd14);

        // halt
        do_reset();
        step({B_HALT, 26'h0}, 1'b0);
        chk("halt_st", 64'(state), 64'h0);
        chk("halt_flag", 64'(Halted), 64'h1);
        chk("halt_cyc", 64'(CycleCnt), 64'h1);
        InsIn = {B_ADD, 26'h0};
        #1;
        chk("halt_irwre", 64'(IRWre), 64'h0);
        for (int i = 0; i < 10; i++) step($urandom, 1'($urandom));
        chk("halt_frz_st", 64'(state), 64'h0);
        chk("halt_frz_cyc", 64'(CycleCnt), 64'h1);
        chk("halt_frz_instr", 64'(InstrCnt), 64'h0);

        // Stall in EXE_5stages
        do_reset();
        step({B_LW, 26'h1}, 1'b0);
        step($urandom, 1'b0);
        chk("stl_exe5", 64'(state), 64'h2);
        for (int i = 0; i < 3; i++) begin
            step($urandom, 1'b1);
            chk("stl_hold", 64'(state), 64'h2);
        end
        chk("stl_cyc", 64'(CycleCnt), 64'd5);
        step($urandom, 1'b0);
        chk("stl_mem", 64'(state), 64'h3);
        step($urandom, 1'b0);
        step($urandom, 1'b0);
        chk("stl_done", 64'(state), 64'h0);
        chk("stl_instr", 64'(InstrCnt), 64'h1);

        // Illegal opcode
        do_reset();
        step({6'b101010, 26'h5}, 1'b0);
        chk("ill_id", 64'(state), 64'h1);
        chk("ill_pre", 64'(IllegalOp), 64'h0);
        step($urandom, 1'b0);
        chk("ill_if", 64'(state), 64'h0);
        chk("ill_pulse", 64'(IllegalOp), 64'h1);
        chk("ill_instr", 64'(InstrCnt), 64'h0);
        step({B_J, 26'h0}, 1'b0);
        chk("ill_clr", 64'(IllegalOp), 64'h0);

        // Reset mid-MEM, asynchronously
        do_reset();
        step({B_SW, 26'h3}, 1'b0);
        step($urandom, 1'b0);
        step($urandom, 1'b0);
        chk("rm_mem", 64'(state), 64'h3);
        #1 RST_n = 1'b0;
        #1;
        chk("rm_state", 64'(state), 64'h0);
        chk("rm_ir", 64'(IR), 64'h0);
        chk("rm_cyc", 64'(CycleCnt), 64'h0);
        chk("rm_instr", 64'(InstrCnt), 64'h0);
        RST_n = 1'b1;
        step(32'h0, 1'b0);

        // Randomized run checked by the negedge compare process
        for (int i = 0; i < 3000; i++) begin
            if (($urandom % 150 == 0) || (m_halt && ($urandom % 8 == 0))) begin
                #1 RST_n = 1'b0;
                #1 RST_n = 1'b1;
            end
            if ($urandom % 100 < 2)       rop = B_HALT;
            else if ($urandom % 10 == 0)  rop = 6'($urandom);
            else                          rop = legal_ops[$urandom % 15];
            step(word(rop), ($urandom % 6) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
